// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one framed-string UART transmitter between
//   NUM_REQ requesters. The winner's string/length are latched into holding
//   registers, a one-cycle tx_req is issued, and the arbiter waits for
//   tx_done or a watchdog timeout before pulsing req_done (and req_err on
//   abort or rejection) back to the winner.
//
// Ports
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req        [N]     : level request per requester
//   req_string [N*W]   : requester i string at [i*STR_W +: STR_W]
//   req_length [N*8]   : requester i payload byte count at [i*8 +: 8]
//   req_grant  [N]     : one-hot grant, high from grant until req_done
//   req_done   [N]     : one-cycle completion pulse
//   req_err    [N]     : one-cycle error pulse, coincident with req_done
//   tx_string  [W]     : latched string to the transmitter
//   tx_length  [8]     : latched length to the transmitter
//   tx_req             : one-cycle transmitter start pulse
//   tx_busy, tx_done   : transmitter status / completion pulse
//   busy               : high whenever the arbiter is not idle
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned STR_W       = 1096,
  parameter int unsigned TIMEOUT_CLK = 2_000_000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*STR_W-1:0]   req_string,
  input  logic [NUM_REQ*8-1:0]       req_length,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [STR_W-1:0]           tx_string,
  output logic [7:0]                 tx_length,
  output logic                       tx_req,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       busy
);

  localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW      = PW + 1;
  localparam int unsigned CW      = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;
  localparam int unsigned MAX_LEN = STR_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        winner_q, winner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [STR_W-1:0]     tx_string_q, tx_string_d;
  logic [7:0]           tx_length_q, tx_length_d;
  logic                 tx_req_q, tx_req_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Round-robin scan: rotate the request vector so rr_ptr lands on bit 0,
  // take the lowest set bit, then add rr_ptr back modulo NUM_REQ.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot_full;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PW-1:0]        arb_off;
  logic                 arb_any;
  logic [SW-1:0]        arb_sum;
  logic [PW-1:0]        arb_win;

  always_comb begin
    req_dbl      = {req, req};
    req_rot_full = req_dbl >> rr_ptr_q;
    req_rot      = req_rot_full[NUM_REQ-1:0];
    arb_off      = '0;
    arb_any      = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_any && req_rot[i]) begin
        arb_any = 1'b1;
        arb_off = PW'(i);
      end
    end
    arb_sum = {1'b0, rr_ptr_q} + {1'b0, arb_off};
    if (arb_sum >= SW'(NUM_REQ)) begin
      arb_sum = arb_sum - SW'(NUM_REQ);
    end
    arb_win = arb_sum[PW-1:0];
  end

  logic          len_bad;
  logic [SW-1:0] ptr_next;

  always_comb begin
    len_bad  = (tx_length_q == '0) || (32'(tx_length_q) > MAX_LEN);
    ptr_next = {1'b0, winner_q} + SW'(1);
    if (ptr_next >= SW'(NUM_REQ)) begin
      ptr_next = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = '0;
    tx_string_d = tx_string_q;
    tx_length_d = tx_length_q;
    tx_req_d    = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // Winner, grant and holding registers are all captured on the
        // IDLE->GRANT edge so req_grant is visible in the GRANT cycle and
        // tx_length is valid alongside tx_req one cycle later.
        if (arb_any && !tx_busy) begin
          state_d          = S_GRANT;
          winner_d         = arb_win;
          grant_d          = '0;
          grant_d[arb_win] = 1'b1;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_win == PW'(i)) begin
              tx_string_d = req_string[i*STR_W +: STR_W];
              tx_length_d = req_length[i*8 +: 8];
            end
          end
        end
      end
      S_GRANT: begin
        if (len_bad) begin
          state_d          = S_RELEASE;
          grant_d          = '0;
          done_d[winner_q] = 1'b1;
          err_d[winner_q]  = 1'b1;
        end else begin
          state_d  = S_LAUNCH;
          tx_req_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q != CW'(TIMEOUT_CLK - 1)) begin
          cnt_d = cnt_q + CW'(1);
        end
        // tx_done takes priority over a coincident watchdog expiry.
        if (tx_done) begin
          state_d          = S_RELEASE;
          grant_d          = '0;
          done_d[winner_q] = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CLK - 1)) begin
          state_d          = S_RELEASE;
          grant_d          = '0;
          done_d[winner_q] = 1'b1;
          err_d[winner_q]  = 1'b1;
        end
      end
      S_RELEASE: begin
        state_d  = S_IDLE;
        rr_ptr_d = ptr_next[PW-1:0];
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      tx_string_q <= '0;
      tx_length_q <= '0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tx_string_q <= tx_string_d;
      tx_length_q <= tx_length_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign tx_string = tx_string_q;
  assign tx_length = tx_length_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: transaction-level reference model with a
// behavioural transmitter, directed scenarios and a randomized phase.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int SW   = 1096;
  localparam int T    = 50;
  localparam int MAXL = SW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*SW-1:0]   req_string;
  logic [N*8-1:0]    req_length;
  logic [N-1:0]      req_grant, req_done, req_err;
  logic [SW-1:0]     tx_string;
  logic [7:0]        tx_length;
  logic              tx_req, tx_busy, tx_done, busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .STR_W(SW),
    .TIMEOUT_CLK(T)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .req(req),
    .req_string(req_string),
    .req_length(req_length),
    .req_grant(req_grant),
    .req_done(req_done),
    .req_err(req_err),
    .tx_string(tx_string),
    .tx_length(tx_length),
    .tx_req(tx_req),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state (transaction level, cycle-stamped events)
  int  ready_cyc = 0, m_ptr = 0;
  bit  inflight = 0, arb_pending = 0, exp_err = 0;
  int  exp_grant_cyc = -1, exp_win = 0, cur_win = 0;
  int  exp_txreq_cyc = -1, exp_done_cyc = -1, done_plan = -1;
  logic [7:0]    lat_len;
  logic [SW-1:0] lat_str;
  int  order[$];
  int  n_done = 0, n_txreq = 0, n_err = 0;
  bit  auto_mode = 0, force_busy = 0, withhold = 0;
  int  fixed_delay = 4, keep_mode = 0;

  function automatic logic [SW-1:0] rand_str();
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < SW / 8; k++) s[k*8 +: 8] = 8'($urandom);
    return s;
  endfunction

  function automatic bit len_ok(input logic [7:0] l);
    return (l != 8'd0) && (int'(l) <= MAXL);
  endfunction

  function automatic logic [7:0] rand_len();
    int r;
    r = int'($urandom % 10);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'($urandom_range(255, MAXL + 1));
    return 8'($urandom_range(MAXL, 1));
  endfunction

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [7:0] len, input logic [SW-1:0] s);
    req[i] = 1'b1;
    req_length[i*8 +: 8] = len;
    req_string[i*SW +: SW] = s;
  endtask

  task automatic clr_req(input int i);
    req[i] = 1'b0;
    req_string[i*SW +: SW] = rand_str();
    req_length[i*8 +: 8] = 8'($urandom);
  endtask

  task automatic arb_eval();
    if (!inflight && !arb_pending && cyc >= ready_cyc && (|req) && !tx_busy) begin
      exp_win       = rr_pick();
      arb_pending   = 1'b1;
      exp_grant_cyc = cyc + 1;
      lat_len       = req_length[exp_win*8 +: 8];
      lat_str       = req_string[exp_win*SW +: SW];
    end
  endtask

  task automatic observe();
    logic [N-1:0] eg, ed;
    bit wh;
    int d;
    if (arb_pending && cyc == exp_grant_cyc) begin
      arb_pending = 1'b0;
      inflight    = 1'b1;
      cur_win     = exp_win;
      order.push_back(cur_win);
      if (len_ok(lat_len)) exp_txreq_cyc = cyc + 1;
      else begin
        exp_done_cyc = cyc + 1;
        exp_err      = 1'b1;
      end
    end
    eg = '0;
    if (inflight && cyc != exp_done_cyc) eg[cur_win] = 1'b1;
    check_eq("req_grant", req_grant, eg);
    check_eq("busy", busy, inflight);
    check_eq("tx_req", tx_req, cyc == exp_txreq_cyc);
    if (tx_req) n_txreq++;
    if (|req_err) n_err++;
    if (cyc == exp_txreq_cyc) begin
      check_eq("tx_length", tx_length, lat_len);
      check_eq("tx_string", tx_string == lat_str, 1'b1);
      wh = withhold || (auto_mode && ($urandom % 10 == 0));
      if (wh) begin
        done_plan    = -1;
        exp_done_cyc = cyc + T + 1;
        exp_err      = 1'b1;
      end else begin
        if (auto_mode) d = ($urandom % 8 == 0) ? T : int'($urandom_range(20, 1));
        else d = fixed_delay;
        done_plan    = cyc + d;
        exp_done_cyc = cyc + d + 1;
        exp_err      = 1'b0;
      end
    end
    ed = '0;
    if (inflight && cyc == exp_done_cyc) ed[cur_win] = 1'b1;
    check_eq("req_done", req_done, ed);
    check_eq("req_err", req_err, exp_err ? ed : '0);
    if (inflight && cyc == exp_done_cyc) begin
      check_eq("tx_length_hold", tx_length, lat_len);
      inflight      = 1'b0;
      m_ptr         = (cur_win + 1) % N;
      ready_cyc     = cyc + 1;
      n_done++;
      exp_txreq_cyc = -1;
      exp_done_cyc  = -1;
      done_plan     = -1;
      if (req[cur_win]) begin
        if (!(keep_mode == 1 || (keep_mode == 2 && ($urandom % 3 == 0)))) clr_req(cur_win);
      end
    end
  endtask

  task automatic drive();
    tx_done = (cyc == done_plan);
    tx_busy = force_busy ? 1'b1 : (auto_mode ? ($urandom % 4 == 0) : 1'b0);
    if (auto_mode) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && inflight && cur_win == i) begin
          if ($urandom % 10 == 0) clr_req(i);
        end else if (!req[i] && !(inflight && cur_win == i) && ($urandom % 6 == 0)) begin
          set_req(i, rand_len(), rand_str());
        end
      end
    end
  endtask

  task automatic step();
    arb_eval();
    @(posedge clk);
    #1;
    cyc++;
    observe();
    drive();
  endtask

  task automatic wait_done(input int n, input int budget);
    int target, k;
    target = n_done + n;
    k = 0;
    while (n_done < target && k < budget) begin
      step();
      k++;
    end
    check_eq("wait_done", n_done >= target, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((inflight || arb_pending) && k < budget) begin
      step();
      k++;
    end
    check_eq("wait_idle", inflight || arb_pending, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_grant", req_grant, '0);
    check_eq("rst_done", req_done, '0);
    check_eq("rst_err", req_err, '0);
    check_eq("rst_tx_req", tx_req, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_tx_length", tx_length, 8'd0);
    check_eq("rst_tx_string", tx_string == '0, 1'b1);
    inflight = 0; arb_pending = 0; exp_err = 0; m_ptr = 0;
    exp_grant_cyc = -1; exp_txreq_cyc = -1; exp_done_cyc = -1; done_plan = -1;
    tx_done = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    ready_cyc = cyc;
    observe();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [SW-1:0] abc;
    int base_tx, base_err;
    req = '0; req_string = '0; req_length = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    do_reset();

    // Single requester "ABC"
    abc = '0;
    abc[23:0] = 24'h434241;
    set_req(0, 8'd3, abc);
    wait_done(1, 40);
    check_eq("single_winner", order[0], 0);
    check_eq("single_txreq_count", n_txreq, 1);
    check_eq("single_err_count", n_err, 0);

    // Fairness with all requests held
    do_reset();
    order.delete();
    keep_mode = 1;
    fixed_delay = 10;
    for (int i = 0; i < N; i++) set_req(i, 8'(5 + i), rand_str());
    wait_done(5, 300);
    keep_mode = 0;
    for (int k = 0; k < 5; k++) check_eq("fair_order", order[k], k % N);
    for (int i = 0; i < N; i++) clr_req(i);
    wait_idle(100);

    // Zero length: rejected, pointer advances to 3
    base_tx = n_txreq; base_err = n_err;
    fixed_delay = 4;
    set_req(2, 8'd0, rand_str());
    wait_done(1, 20);
    check_eq("zero_len_txreq", n_txreq - base_tx, 0);
    check_eq("zero_len_err", n_err - base_err, 1);
    order.delete();
    set_req(0, 8'd2, rand_str());
    set_req(1, 8'd138, rand_str());
    set_req(3, 8'(MAXL), rand_str());
    wait_done(3, 200);
    check_eq("after_reject_0", order[0], 3);
    check_eq("after_reject_1", order[1], 0);
    check_eq("after_reject_2", order[2], 1);

    // Watchdog timeout, then normal service of the next requester
    base_err = n_err;
    order.delete();
    withhold = 1;
    set_req(0, 8'd7, rand_str());
    set_req(1, 8'd9, rand_str());
    wait_done(1, 100);
    withhold = 0;
    fixed_delay = 3;
    wait_done(1, 30);
    check_eq("timeout_err", n_err - base_err, 1);
    check_eq("timeout_order0", order[0], 0);
    check_eq("timeout_order1", order[1], 1);

    // tx_done on the last watchdog cycle wins
    base_err = n_err;
    fixed_delay = T;
    set_req(2, 8'd11, rand_str());
    wait_done(1, 100);
    check_eq("race_no_err", n_err - base_err, 0);
    fixed_delay = 4;

    // tx_busy gating while idle
    force_busy = 1;
    set_req(1, 8'd4, rand_str());
    repeat (20) step();
    check_eq("busy_gate_grant", req_grant, '0);
    force_busy = 0;
    wait_done(1, 30);

    // Reset during WAIT: pointer returns to 0
    set_req(2, 8'd6, rand_str());
    wait_done(1, 30);
    withhold = 1;
    base_tx = n_txreq;
    set_req(1, 8'd6, rand_str());
    for (int k = 0; k < 20 && n_txreq == base_tx; k++) step();
    check_eq("mid_wait_launch", n_txreq - base_tx, 1);
    repeat (5) step();
    set_req(3, 8'd8, rand_str());
    withhold = 0;
    do_reset();
    order.delete();
    fixed_delay = 3;
    wait_done(2, 60);
    check_eq("post_reset_order0", order[0], 1);
    check_eq("post_reset_order1", order[1], 3);

    // Randomized traffic
    auto_mode = 1;
    keep_mode = 2;
    repeat (3000) step();
    auto_mode = 0;
    keep_mode = 0;
    for (int i = 0; i < N; i++) clr_req(i);
    wait_idle(200);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
